// File: rtl/fpga_clock_gate_pkg.sv
// Shared types and default widths for the FPGA DUT clock-gate enable controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package fpga_clock_gate_pkg;

    localparam int unsigned DEF_CNT_W  = 64;
    localparam int unsigned DEF_STEP_W = 32;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } cg_state_e;

endpackage

// File: rtl/fpga_clock_gate_wdog.sv
// Stall-timeout watchdog: flags a DUT clock held off by buf_stall for too long while not halted.
// Latency: trip is combinational in the cycle the count would reach all-ones; wdog_err registers on that edge.
// Backpressure: none; observes buf_stall only, error is sticky until reset.
module fpga_clock_gate_wdog #(
    parameter int unsigned WDOG_W = 24
) (
    input  logic clock,
    input  logic reset,
    input  logic active,
    input  logic buf_stall,
    output logic trip,
    output logic wdog_err
);

    // Count value one short of the all-ones limit; the cycle that would reach the limit trips.
    localparam logic [WDOG_W-1:0] WD_PRE_LIMIT = {{(WDOG_W-1){1'b1}}, 1'b0};

    logic [WDOG_W-1:0] wd_q, wd_d;
    logic              err_q, err_d;
    logic              stalled;

    // Consecutive stalled-while-active count; any clean cycle or a trip restarts it.
    always_comb begin
        stalled = active & buf_stall;
        trip    = stalled & (wd_q == WD_PRE_LIMIT);
        wd_d    = '0;
        if (stalled && !trip) begin
            wd_d = wd_q + 1'b1;
        end
        err_d   = err_q | trip;
    end

    // Counter and sticky error register.
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign wdog_err = err_q;

endmodule

// File: rtl/fpga_clock_gate_ctrl.sv
// Registered, glitch-free enable for the DUT clock gate E input; arbitrates host run/halt/step vs buf_stall.
// Latency: every input reaches clk_en through exactly one flop; cycle_cnt counts completed clk_en=1 cycles.
// Backpressure: buf_stall suppresses clk_en next cycle without changing state; optional stall watchdog via FPGA_CLOCK_GATE_WATCHDOG_EN.
module fpga_clock_gate_ctrl
    import fpga_clock_gate_pkg::*;
#(
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned STEP_W       = DEF_STEP_W,
    parameter bit          RUN_ON_RESET = 1'b0,
    parameter int unsigned WDOG_W       = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_run,
    input  logic              host_halt,
    input  logic              host_step_valid,
    output logic              host_step_ready,
    input  logic [STEP_W-1:0] host_step_cnt,
    input  logic              buf_stall,
    output logic              clk_en,
    output logic [1:0]        state,
    output logic              step_done,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              wdog_err
);

    localparam cg_state_e RESET_STATE = RUN_ON_RESET ? ST_RUN : ST_HALT;

    cg_state_e          state_q, state_d, state_cmd;
    logic [STEP_W-1:0]  rem_q, rem_d, rem_cmd, rem_dec;
    logic               clk_en_q, clk_en_d;
    logic               last_q, last_d;
    logic               step_done_q, step_done_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic               zero_step;
    logic               step_acc;
    logic               run_ok;
    logic               wd_trip;

    // The watchdog counter needs at least two bits for a meaningful limit; nothing is built here.
    if (WDOG_W < 2) begin : g_wdog_w_too_small
    end

`ifdef FPGA_CLOCK_GATE_WATCHDOG_EN
    fpga_clock_gate_wdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .clock     (clock),
        .reset     (reset),
        .active    (state_q != ST_HALT),
        .buf_stall (buf_stall),
        .trip      (wd_trip),
        .wdog_err  (wdog_err)
    );
`else
    assign wd_trip  = 1'b0;
    assign wdog_err = 1'b0;
`endif

    // Steps are only taken while halted; a tripped watchdog locks out new work until reset.
    assign host_step_ready = (state_q == ST_HALT) & ~wdog_err;
    assign step_acc        = host_step_valid & host_step_ready;
    assign run_ok          = host_run & ~wdog_err;

    // Command decode: pick the state being entered, priority host_halt > step accept > host_run.
    always_comb begin
        state_cmd = state_q;
        rem_cmd   = rem_q;
        zero_step = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (!host_halt) begin
                    if (step_acc) begin
                        if (host_step_cnt == '0) begin
                            zero_step = 1'b1;
                        end else begin
                            state_cmd = ST_STEP;
                            rem_cmd   = host_step_cnt;
                        end
                    end else if (run_ok) begin
                        state_cmd = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (host_halt) begin
                    state_cmd = ST_HALT;
                end
            end
            ST_STEP: begin
                if (host_halt) begin
                    state_cmd = ST_HALT;
                    rem_cmd   = '0;
                end else if (run_ok) begin
                    state_cmd = ST_RUN;
                    rem_cmd   = '0;
                end
            end
            default: begin
                state_cmd = ST_HALT;
                rem_cmd   = '0;
            end
        endcase
    end

    // Edge grant, decided for the state being entered so commands and stalls reach clk_en in one flop.
    always_comb begin
        clk_en_d = 1'b0;
        rem_dec  = rem_cmd;
        last_d   = 1'b0;
        if (!wd_trip) begin
            if (state_cmd == ST_RUN) begin
                clk_en_d = ~buf_stall;
            end else if ((state_cmd == ST_STEP) && (rem_cmd != '0) && !buf_stall) begin
                clk_en_d = 1'b1;
                rem_dec  = rem_cmd - STEP_W'(1);
                last_d   = (rem_cmd == STEP_W'(1));
            end
        end
        // last_q marks the final stepped clk_en cycle, so done lands one cycle after it.
        step_done_d = zero_step | last_q;
        cycle_cnt_d = cycle_cnt_q + CNT_W'(clk_en_q);
    end

    // Next state: the final granted step edge and a watchdog trip both return to HALT.
    always_comb begin
        state_d = state_cmd;
        rem_d   = rem_dec;
        if (wd_trip) begin
            state_d = ST_HALT;
            rem_d   = '0;
        end else if (last_d) begin
            state_d = ST_HALT;
        end
    end

    // State, step counter, enable and accounting registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            rem_q       <= '0;
            clk_en_q    <= 1'b0;
            last_q      <= 1'b0;
            step_done_q <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            clk_en_q    <= clk_en_d;
            last_q      <= last_d;
            step_done_q <= step_done_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign clk_en    = clk_en_q;
    assign state     = state_q;
    assign step_done = step_done_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_fpga_clock_gate_ctrl.sv
// Self-checking bench for fpga_clock_gate_ctrl: per-cycle expected {clk_en, step_done, state} scoreboard.
// Latency: outputs sampled 1 ns after each rising edge; inputs driven at the same point for the next edge.
// Backpressure: buf_stall patterns are table driven per scenario; watchdog scenario under FPGA_CLOCK_GATE_WATCHDOG_EN.
module tb_fpga_clock_gate_ctrl;

    localparam logic [1:0] S_HALT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;

    typedef struct packed {
        logic       en;
        logic       done;
        logic [1:0] st;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        host_run;
    logic        host_halt;
    logic        host_step_valid;
    logic        host_step_ready;
    logic [31:0] host_step_cnt;
    logic        buf_stall;
    logic        clk_en;
    logic [1:0]  state;
    logic        step_done;
    logic [63:0] cycle_cnt;
    logic        wdog_err;

    exp_t        sb[$];
    longint unsigned exp_cnt;
    int          checks;
    int          errors;

    fpga_clock_gate_ctrl #(
        .CNT_W        (64),
        .STEP_W       (32),
        .RUN_ON_RESET (1'b0),
        .WDOG_W       (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .host_run        (host_run),
        .host_halt       (host_halt),
        .host_step_valid (host_step_valid),
        .host_step_ready (host_step_ready),
        .host_step_cnt   (host_step_cnt),
        .buf_stall       (buf_stall),
        .clk_en          (clk_en),
        .state           (state),
        .step_done       (step_done),
        .cycle_cnt       (cycle_cnt),
        .wdog_err        (wdog_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t mk(input logic en, input logic done, input logic [1:0] st);
        exp_t r;
        r.en = en; r.done = done; r.st = st;
        return r;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        host_run = 1'b0; host_halt = 1'b0; host_step_valid = 1'b0;
        host_step_cnt = 32'd0; buf_stall = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({clk_en, step_done, state} !== {1'b0, 1'b0, S_HALT}) begin
                errors++;
                $display("FAIL reset_outputs[%0d] got en=%b done=%b st=%0d want en=0 done=0 st=0", i, clk_en, step_done, state);
            end
            checks++;
            if (cycle_cnt !== 64'd0) begin
                errors++;
                $display("FAIL reset_cycle_cnt[%0d] got %0d want 0", i, cycle_cnt);
            end
            checks++;
            if ({wdog_err, host_step_ready} !== 2'b01) begin
                errors++;
                $display("FAIL reset_wdog_ready[%0d] got wdog_err=%b ready=%b want 0 1", i, wdog_err, host_step_ready);
            end
        end
    endtask

    task automatic test_run_halt;
        exp_t e;
        for (int i = 0; i < 20; i++) begin sb.push_back(mk(1'b1, 1'b0, S_RUN)); exp_cnt++; end
        sb.push_back(mk(1'b0, 1'b0, S_HALT));
        sb.push_back(mk(1'b0, 1'b0, S_HALT));
        for (int i = 0; i < 22; i++) begin
            idle_inputs();
            host_run  = (i == 0);
            host_halt = (i == 20);
            tick();
            e = sb.pop_front();
            checks++;
            if ({clk_en, step_done, state} !== e) begin
                errors++;
                $display("FAIL run_halt[%0d] got en=%b done=%b st=%0d want en=%b done=%b st=%0d", i, clk_en, step_done, state, e.en, e.done, e.st);
            end
            if (i == 0) begin
                checks++;
                if (host_step_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL run_step_ready got %b want 0", host_step_ready);
                end
            end
        end
        checks++;
        if (cycle_cnt !== 64'(exp_cnt)) begin
            errors++;
            $display("FAIL run_cycle_cnt got %0d want %0d", cycle_cnt, exp_cnt);
        end
    endtask

    task automatic test_step5;
        exp_t e;
        for (int i = 0; i < 4; i++) sb.push_back(mk(1'b1, 1'b0, S_STEP));
        sb.push_back(mk(1'b1, 1'b0, S_HALT));
        sb.push_back(mk(1'b0, 1'b1, S_HALT));
        sb.push_back(mk(1'b0, 1'b0, S_HALT));
        exp_cnt += 5;
        checks++;
        if (host_step_ready !== 1'b1) begin
            errors++;
            $display("FAIL step5_ready got %b want 1", host_step_ready);
        end
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            host_step_valid = (i == 0);
            host_step_cnt   = 32'd5;
            tick();
            e = sb.pop_front();
            checks++;
            if ({clk_en, step_done, state} !== e) begin
                errors++;
                $display("FAIL step5[%0d] got en=%b done=%b st=%0d want en=%b done=%b st=%0d", i, clk_en, step_done, state, e.en, e.done, e.st);
            end
        end
        checks++;
        if (cycle_cnt !== 64'(exp_cnt)) begin
            errors++;
            $display("FAIL step5_cycle_cnt got %0d want %0d", cycle_cnt, exp_cnt);
        end
    endtask

    task automatic test_step_stall;
        exp_t e;
        sb.push_back(mk(1'b1, 1'b0, S_STEP));
        sb.push_back(mk(1'b1, 1'b0, S_STEP));
        for (int i = 0; i < 3; i++) sb.push_back(mk(1'b0, 1'b0, S_STEP));
        sb.push_back(mk(1'b1, 1'b0, S_STEP));
        sb.push_back(mk(1'b1, 1'b0, S_STEP));
        sb.push_back(mk(1'b1, 1'b0, S_HALT));
        sb.push_back(mk(1'b0, 1'b1, S_HALT));
        sb.push_back(mk(1'b0, 1'b0, S_HALT));
        exp_cnt += 5;
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            host_step_valid = (i == 0);
            host_step_cnt   = 32'd5;
            buf_stall       = (i >= 2) && (i <= 4);
            tick();
            e = sb.pop_front();
            checks++;
            if ({clk_en, step_done, state} !== e) begin
                errors++;
                $display("FAIL step_stall[%0d] got en=%b done=%b st=%0d want en=%b done=%b st=%0d", i, clk_en, step_done, state, e.en, e.done, e.st);
            end
        end
        checks++;
        if (cycle_cnt !== 64'(exp_cnt)) begin
            errors++;
            $display("FAIL step_stall_cycle_cnt got %0d want %0d", cycle_cnt, exp_cnt);
        end
    endtask

    task automatic test_step_zero;
        exp_t e;
        sb.push_back(mk(1'b0, 1'b1, S_HALT));
        sb.push_back(mk(1'b0, 1'b0, S_HALT));
        sb.push_back(mk(1'b0, 1'b0, S_HALT));
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            host_step_valid = (i == 0);
            host_step_cnt   = 32'd0;
            tick();
            e = sb.pop_front();
            checks++;
            if ({clk_en, step_done, state} !== e) begin
                errors++;
                $display("FAIL step_zero[%0d] got en=%b done=%b st=%0d want en=%b done=%b st=%0d", i, clk_en, step_done, state, e.en, e.done, e.st);
            end
        end
        checks++;
        if (cycle_cnt !== 64'(exp_cnt)) begin
            errors++;
            $display("FAIL step_zero_cycle_cnt got %0d want %0d", cycle_cnt, exp_cnt);
        end
    endtask

    task automatic test_step_abort;
        exp_t e;
        // Step 10 aborted by host_halt, then step 10 taken over by host_run.
        for (int i = 0; i < 3; i++) sb.push_back(mk(1'b1, 1'b0, S_STEP));
        for (int i = 0; i < 3; i++) sb.push_back(mk(1'b0, 1'b0, S_HALT));
        for (int i = 0; i < 3; i++) sb.push_back(mk(1'b1, 1'b0, S_STEP));
        sb.push_back(mk(1'b1, 1'b0, S_RUN));
        sb.push_back(mk(1'b0, 1'b0, S_HALT));
        sb.push_back(mk(1'b0, 1'b0, S_HALT));
        exp_cnt += 7;
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            host_step_cnt   = 32'd10;
            host_step_valid = (i == 0) || (i == 6);
            host_halt       = (i == 3) || (i == 10);
            host_run        = (i == 9);
            tick();
            e = sb.pop_front();
            checks++;
            if ({clk_en, step_done, state} !== e) begin
                errors++;
                $display("FAIL step_abort[%0d] got en=%b done=%b st=%0d want en=%b done=%b st=%0d", i, clk_en, step_done, state, e.en, e.done, e.st);
            end
        end
        checks++;
        if (cycle_cnt !== 64'(exp_cnt)) begin
            errors++;
            $display("FAIL step_abort_cycle_cnt got %0d want %0d", cycle_cnt, exp_cnt);
        end
    endtask

    task automatic test_same_cycle;
        exp_t e;
        sb.push_back(mk(1'b1, 1'b0, S_RUN));
        sb.push_back(mk(1'b0, 1'b0, S_RUN));
        sb.push_back(mk(1'b1, 1'b0, S_RUN));
        sb.push_back(mk(1'b0, 1'b0, S_HALT));
        sb.push_back(mk(1'b0, 1'b0, S_HALT));
        exp_cnt += 2;
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            host_run  = (i == 0) || (i == 3);
            buf_stall = (i == 1);
            host_halt = (i == 3);
            tick();
            e = sb.pop_front();
            checks++;
            if ({clk_en, step_done, state} !== e) begin
                errors++;
                $display("FAIL same_cycle[%0d] got en=%b done=%b st=%0d want en=%b done=%b st=%0d", i, clk_en, step_done, state, e.en, e.done, e.st);
            end
        end
        checks++;
        if (cycle_cnt !== 64'(exp_cnt)) begin
            errors++;
            $display("FAIL same_cycle_cycle_cnt got %0d want %0d", cycle_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_step;
        exp_t e;
        for (int i = 0; i < 10; i++) sb.push_back(mk(1'b1, 1'b0, S_STEP));
        for (int i = 0; i < 5; i++) sb.push_back(mk(1'b0, 1'b0, S_HALT));
        for (int i = 0; i < 15; i++) begin
            idle_inputs();
            host_step_valid = (i == 0);
            host_step_cnt   = 32'd100;
            reset           = (i == 10);
            tick();
            e = sb.pop_front();
            checks++;
            if ({clk_en, step_done, state} !== e) begin
                errors++;
                $display("FAIL reset_mid_step[%0d] got en=%b done=%b st=%0d want en=%b done=%b st=%0d", i, clk_en, step_done, state, e.en, e.done, e.st);
            end
        end
        reset = 1'b0;
        exp_cnt = 0;
        checks++;
        if (cycle_cnt !== 64'(exp_cnt)) begin
            errors++;
            $display("FAIL reset_mid_step_cycle_cnt got %0d want %0d", cycle_cnt, exp_cnt);
        end
    endtask

`ifdef FPGA_CLOCK_GATE_WATCHDOG_EN
    task automatic test_watchdog;
        exp_t e;
        sb.push_back(mk(1'b1, 1'b0, S_RUN));
        for (int i = 1; i < 15; i++) sb.push_back(mk(1'b0, 1'b0, S_RUN));
        for (int i = 15; i < 19; i++) sb.push_back(mk(1'b0, 1'b0, S_HALT));
        for (int i = 0; i < 19; i++) begin
            idle_inputs();
            host_run        = (i == 0) || (i == 16);
            host_step_valid = (i == 17);
            host_step_cnt   = 32'd3;
            buf_stall       = (i >= 1) && (i <= 15);
            tick();
            e = sb.pop_front();
            checks++;
            if ({clk_en, step_done, state} !== e) begin
                errors++;
                $display("FAIL watchdog[%0d] got en=%b done=%b st=%0d want en=%b done=%b st=%0d", i, clk_en, step_done, state, e.en, e.done, e.st);
            end
            checks++;
            if (wdog_err !== (i >= 15)) begin
                errors++;
                $display("FAIL watchdog_err[%0d] got %b want %b", i, wdog_err, (i >= 15));
            end
        end
        checks++;
        if (host_step_ready !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_ready got %b want 0", host_step_ready);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cnt = 0;
        checks++;
        if ({wdog_err, host_step_ready, state} !== {1'b0, 1'b1, S_HALT}) begin
            errors++;
            $display("FAIL watchdog_reset got err=%b ready=%b st=%0d want 0 1 0", wdog_err, host_step_ready, state);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        exp_cnt = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_run_halt();
        test_step5();
        test_step_stall();
        test_step_zero();
        test_step_abort();
        test_same_cycle();
        test_reset_mid_step();
`ifdef FPGA_CLOCK_GATE_WATCHDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no completion want finish before 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
